// File: rtl/layer_scan_sequencer.sv
// layer_scan_sequencer
// Scans a double-buffered 8-layer frame onto the cube. Each layer is loaded onto
// the column bus, the layer activator is kicked with a one-cycle start pulse,
// and the sequencer waits for its done pulse (or a timeout) before advancing.
// A newly written back frame becomes visible only at a frame boundary, after
// FRAME_REPEAT complete scans of the current front frame.
// Build option: define LAYER_SCAN_BLANK_GAP_EN to insert DEAD_TIME blank cycles
// (columns forced to zero) between layers.
module layer_scan_sequencer #(
  parameter int FRAME_REPEAT = 16,
  parameter int TIMEOUT      = 4095,
  parameter int DEAD_TIME    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_layer,
  input  logic [63:0] wr_data,
  input  logic        wr_last,
  output logic        scan_start,
  output logic [2:0]  scan_layer,
  input  logic        scan_done,
  output logic [63:0] col_data,
  output logic        frame_swapped,
  output logic        timeout_err
);

  localparam int RPT_W = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(FRAME_REPEAT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  // Reject parameter values the counters cannot represent sensibly.
  if (FRAME_REPEAT < 1) begin : g_bad_repeat
    $error("FRAME_REPEAT must be at least 1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end
  if (DEAD_TIME < 1) begin : g_bad_dead_time
    $error("DEAD_TIME must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4
`ifdef LAYER_SCAN_BLANK_GAP_EN
    , ST_BLANK = 3'd5
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        layer_q, layer_d;
  logic [RPT_W-1:0]  repeat_cnt_q, repeat_cnt_d;
  logic [TMO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              front_sel_q, front_sel_d;
  logic              pending_q, pending_d;
  logic [63:0]       col_data_q, col_data_d;
  logic [2:0]        scan_layer_q, scan_layer_d;
  logic              frame_swapped_q, frame_swapped_d;
  logic              timeout_err_q, timeout_err_d;
  logic [63:0]       buf_q [0:1][0:7];
  logic [63:0]       buf_d [0:1][0:7];

`ifdef LAYER_SCAN_BLANK_GAP_EN
  localparam int DT_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEAD_TIME - 1);
  logic [DT_W-1:0]   blank_cnt_q, blank_cnt_d;
`endif

  logic              wr_fire;
  logic [TMO_W-1:0]  wait_inc;
  logic              wait_expired;

  // The back buffer only accepts writes until a complete frame is waiting.
  assign wr_fire      = wr_valid & ~pending_q;
  assign wait_inc     = wait_cnt_q + 1'b1;
  assign wait_expired = (state_q == ST_WAIT) && !scan_done && (wait_inc == TMO_LAST);

  assign wr_ready      = ~pending_q;
  assign scan_layer    = scan_layer_q;
  assign col_data      = col_data_q;
  assign frame_swapped = frame_swapped_q;
  assign timeout_err   = timeout_err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: done or timeout ends a layer; enable is honoured at layer boundaries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (scan_done || wait_expired) state_d = ST_NEXT;
      ST_NEXT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
`ifdef LAYER_SCAN_BLANK_GAP_EN
          state_d = ST_BLANK;
`else
          state_d = ST_LOAD;
`endif
        end
      end
`ifdef LAYER_SCAN_BLANK_GAP_EN
      ST_BLANK: if (blank_cnt_q == DT_LAST) state_d = ST_LOAD;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: the activator start pulse lasts exactly the START cycle.
  always_comb begin
    scan_start = (state_q == ST_START);
  end

  // Datapath next values: buffer writes, layer/repeat bookkeeping, swap and timeout.
  always_comb begin
    layer_d         = layer_q;
    repeat_cnt_d    = repeat_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    front_sel_d     = front_sel_q;
    pending_d       = pending_q;
    col_data_d      = col_data_q;
    scan_layer_d    = scan_layer_q;
    frame_swapped_d = 1'b0;
    timeout_err_d   = timeout_err_q;
    buf_d           = buf_q;
`ifdef LAYER_SCAN_BLANK_GAP_EN
    blank_cnt_d     = blank_cnt_q;
`endif

    // Writes always land in the back buffer; a frame only counts once wr_last arrives.
    if (wr_fire) begin
      buf_d[~front_sel_q][wr_layer] = wr_data;
      if (wr_last) pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        col_data_d = '0;
        layer_d    = '0;
      end
      ST_LOAD: begin
        col_data_d   = buf_q[front_sel_q][layer_q];
        scan_layer_d = layer_q;
      end
      ST_START: begin
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (!scan_done) begin
          wait_cnt_d = wait_inc;
          if (wait_expired) timeout_err_d = 1'b1;
        end
      end
      ST_NEXT: begin
        layer_d = layer_q + 3'd1;
        if (layer_q == 3'd7) begin
          if (repeat_cnt_q == RPT_LAST) begin
            repeat_cnt_d = '0;
            // Swap decision uses the registered flag, so a wr_last landing in
            // this very cycle waits for the following frame boundary.
            if (pending_q) begin
              front_sel_d     = ~front_sel_q;
              pending_d       = 1'b0;
              frame_swapped_d = 1'b1;
            end
          end else begin
            repeat_cnt_d = repeat_cnt_q + 1'b1;
          end
        end
        if (!enable) begin
          layer_d      = '0;
          repeat_cnt_d = '0;
          col_data_d   = '0;
        end
`ifdef LAYER_SCAN_BLANK_GAP_EN
        else begin
          col_data_d  = '0;
          blank_cnt_d = '0;
        end
`endif
      end
`ifdef LAYER_SCAN_BLANK_GAP_EN
      ST_BLANK: begin
        blank_cnt_d = blank_cnt_q + 1'b1;
      end
`endif
      default: begin
        col_data_d = '0;
      end
    endcase
  end

  // Datapath registers, including both frame buffers which reset to blank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      layer_q         <= '0;
      repeat_cnt_q    <= '0;
      wait_cnt_q      <= '0;
      front_sel_q     <= 1'b0;
      pending_q       <= 1'b0;
      col_data_q      <= '0;
      scan_layer_q    <= '0;
      frame_swapped_q <= 1'b0;
      timeout_err_q   <= 1'b0;
`ifdef LAYER_SCAN_BLANK_GAP_EN
      blank_cnt_q     <= '0;
`endif
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < 8; l++) begin
          buf_q[b][l] <= '0;
        end
      end
    end else begin
      layer_q         <= layer_d;
      repeat_cnt_q    <= repeat_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      front_sel_q     <= front_sel_d;
      pending_q       <= pending_d;
      col_data_q      <= col_data_d;
      scan_layer_q    <= scan_layer_d;
      frame_swapped_q <= frame_swapped_d;
      timeout_err_q   <= timeout_err_d;
`ifdef LAYER_SCAN_BLANK_GAP_EN
      blank_cnt_q     <= blank_cnt_d;
`endif
      buf_q           <= buf_d;
    end
  end

endmodule
